// File: rtl/datainf_rr_arbiter.sv
// datainf_rr_arbiter
// Round-robin merge of NUM valid/ready requester streams onto one registered
// downstream stream. A grant lasts up to BURST beats and always passes through
// one IDLE arbitration cycle before the next owner is chosen. Masked requesters
// are permanently ready and have their data silently discarded.

module datainf_rr_arbiter #(
  parameter int NUM   = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic [NUM-1:0]           mask,
  input  logic [NUM-1:0]           s_valid,
  input  logic [NUM*DSIZE-1:0]     s_data,
  output logic [NUM-1:0]           s_ready,
  output logic                     m_valid,
  output logic [DSIZE-1:0]         m_data,
  input  logic                     m_ready,
  output logic [$clog2(NUM)-1:0]   grant_id,
  output logic                     busy
);

  localparam int GW = $clog2(NUM);
  localparam int CW = $clog2(BURST + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [CW-1:0] LAST_BEAT  = CW'(BURST - 1);
  localparam logic [GW-1:0] RESET_LAST = GW'(NUM - 1);

  logic [0:0]       state;
  logic [GW-1:0]    last;
  logic [CW-1:0]    cnt;

  logic [NUM-1:0]   req;
  logic [GW-1:0]    cand;
  logic [GW-1:0]    pick;
  logic             found;

  logic             owner_valid;
  logic             owner_mask;
  logic [DSIZE-1:0] owner_data;
  logic             owner_ready;
  logic             xfer;
  logic             release_grant;

  assign req         = s_valid & ~mask;
  assign owner_ready = !m_valid || m_ready;
  assign xfer        = (state == ST_BUSY) && owner_valid && !owner_mask && owner_ready;
  assign release_grant = (state == ST_BUSY) &&
                         ((xfer && (cnt == LAST_BEAT)) || !owner_valid || owner_mask);
  assign busy        = (state == ST_BUSY);

  // Rotating-priority search: first active request after the previous owner
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM; k++) begin
      cand = GW'((int'(last) + k) % NUM);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // Select the current owner's valid, mask and data lanes
  always_comb begin
    owner_valid = 1'b0;
    owner_mask  = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM; i++) begin
      if (grant_id == GW'(i)) begin
        owner_valid = s_valid[i];
        owner_mask  = mask[i];
        owner_data  = s_data[i*DSIZE +: DSIZE];
      end
    end
  end

  // Masked lanes always drain; only the unmasked owner sees the output slot
  always_comb begin
    s_ready = mask;
    for (int i = 0; i < NUM; i++) begin
      if ((state == ST_BUSY) && (grant_id == GW'(i)) && !mask[i]) begin
        s_ready[i] = owner_ready;
      end
    end
  end

  // Grant state machine: arbitrate in IDLE, count beats and release in BUSY
  always_ff @(posedge clock) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant_id <= '0;
      last     <= RESET_LAST;
      cnt      <= '0;
    end else if (state == ST_IDLE) begin
      if (found) begin
        state    <= ST_BUSY;
        grant_id <= pick;
        cnt      <= '0;
      end
    end else begin
      if (xfer) begin
        cnt <= cnt + CW'(1);
      end
      if (release_grant) begin
        state <= ST_IDLE;
        last  <= grant_id;
      end
    end
  end

  // Registered output slot: load on transfer, empty when drained downstream
  always_ff @(posedge clock) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (xfer) begin
      m_valid <= 1'b1;
      m_data  <= owner_data;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_datainf_rr_arbiter.sv
// tb_datainf_rr_arbiter
// Self-checking bench: a fixed single-requester vector table, hand-written
// corner sequences and a long randomized run, all checked against a
// cycle-level behavioural model plus an order-preserving beat scoreboard.

module tb_datainf_rr_arbiter;

  localparam int NUM   = 4;
  localparam int DSIZE = 8;
  localparam int BURST = 4;

  logic         clock = 1'b0;
  logic         rst;
  logic [3:0]   mask;
  logic [3:0]   s_valid;
  logic [31:0]  s_data;
  logic [3:0]   s_ready;
  logic         m_valid;
  logic [7:0]   m_data;
  logic         m_ready;
  logic [1:0]   grant_id;
  logic         busy;

  int tests = 0;
  int fails = 0;

  // behavioural model state: owner -1 means no grant
  int         md_owner;
  int         md_beats;
  int         md_last;
  int         md_grant;
  logic       md_mvalid;
  logic [7:0] md_mdata;
  bit         check_en = 1'b0;

  logic [7:0] sb_q[$];
  logic [7:0] out_log[$];

  typedef struct {
    logic [3:0] valid;
    logic [7:0] data0;
    logic       exp_busy;
    logic       exp_mv;
    logic [7:0] exp_md;
    logic [3:0] exp_ready;
  } vec_t;

  vec_t vecs[12];

  datainf_rr_arbiter #(.NUM(NUM), .DSIZE(DSIZE), .BURST(BURST)) dut (
    .clock    (clock),
    .rst      (rst),
    .mask     (mask),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_ready  (m_ready),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    md_owner  = -1;
    md_beats  = 0;
    md_last   = NUM - 1;
    md_grant  = 0;
    md_mvalid = 1'b0;
    md_mdata  = 8'h00;
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] mk, input logic [3:0] v,
                               input logic [31:0] d, input logic mr);
    rst     = r;
    mask    = mk;
    s_valid = v;
    s_data  = d;
    m_ready = mr;
  endtask

  // Compare DUT against the model and track beats through the scoreboard
  task automatic checkOutput();
    logic [3:0] exp_ready;
    if (check_en) begin
      for (int i = 0; i < NUM; i++)
        exp_ready[i] = mask[i] | ((md_owner == i) && (!md_mvalid || m_ready));
      checkVal("s_ready", 32'(s_ready), 32'(exp_ready));
      checkVal("m_valid", 32'(m_valid), 32'(md_mvalid));
      checkVal("m_data", 32'(m_data), 32'(md_mdata));
      checkVal("grant_id", 32'(grant_id), 32'(md_grant));
      checkVal("busy", 32'(busy), 32'(md_owner >= 0));
      if (m_valid && m_ready) begin
        out_log.push_back(m_data);
        checkVal("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) checkVal("sb_order", 32'(m_data), 32'(sb_q.pop_front()));
      end
      if (rst) sb_q.delete();
      else
        for (int i = 0; i < NUM; i++)
          if (s_valid[i] && s_ready[i] && !mask[i]) sb_q.push_back(s_data[i*8 +: 8]);
    end
  endtask

  task automatic model_step();
    int  idx;
    int  g;
    bit  acc;
    if (rst) begin
      model_reset();
    end else if (md_owner < 0) begin
      for (int k = 1; k <= NUM; k++) begin
        idx = (md_last + k) % NUM;
        if (md_owner < 0 && s_valid[idx] && !mask[idx]) begin
          md_owner = idx;
          md_grant = idx;
          md_beats = 0;
        end
      end
      if (m_ready) md_mvalid = 1'b0;
    end else begin
      g   = md_owner;
      acc = s_valid[g] && !mask[g] && (!md_mvalid || m_ready);
      if (acc) begin
        md_mdata  = s_data[g*8 +: 8];
        md_mvalid = 1'b1;
        md_beats++;
      end else if (m_ready) begin
        md_mvalid = 1'b0;
      end
      if ((acc && md_beats == BURST) || !s_valid[g] || mask[g]) begin
        md_last  = g;
        md_owner = -1;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clock);
    checkOutput();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] mk);
    applyStimulus(1'b1, mk, 4'b0000, 32'h0, 1'b1);
    cycle();
    check_en = 1'b1;
  endtask

  // Hard time limit so the bench always terminates
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int cnt41;
    bit seen40;
    bit seen42;

    vecs[0]  = '{4'b0001, 8'h10, 1'b0, 1'b0, 8'h00, 4'b0000};
    vecs[1]  = '{4'b0001, 8'h10, 1'b1, 1'b0, 8'h00, 4'b0001};
    vecs[2]  = '{4'b0001, 8'h11, 1'b1, 1'b1, 8'h10, 4'b0001};
    vecs[3]  = '{4'b0001, 8'h12, 1'b1, 1'b1, 8'h11, 4'b0001};
    vecs[4]  = '{4'b0001, 8'h13, 1'b1, 1'b1, 8'h12, 4'b0001};
    vecs[5]  = '{4'b0001, 8'h14, 1'b0, 1'b1, 8'h13, 4'b0000};
    vecs[6]  = '{4'b0001, 8'h14, 1'b1, 1'b0, 8'h13, 4'b0001};
    vecs[7]  = '{4'b0001, 8'h15, 1'b1, 1'b1, 8'h14, 4'b0001};
    vecs[8]  = '{4'b0001, 8'h16, 1'b1, 1'b1, 8'h15, 4'b0001};
    vecs[9]  = '{4'b0001, 8'h17, 1'b1, 1'b1, 8'h16, 4'b0001};
    vecs[10] = '{4'b0000, 8'h00, 1'b0, 1'b1, 8'h17, 4'b0000};
    vecs[11] = '{4'b0000, 8'h00, 1'b0, 1'b0, 8'h17, 4'b0000};

    #1;
    do_reset(4'b0000);
    checkVal("rst_m_valid", 32'(m_valid), 32'd0);
    checkVal("rst_m_data", 32'(m_data), 32'd0);
    checkVal("rst_grant_id", 32'(grant_id), 32'd0);
    checkVal("rst_busy", 32'(busy), 32'd0);

    // single requester, 8 beats with an IDLE gap after every 4
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 4'b0000, vecs[i].valid, {24'h0, vecs[i].data0}, 1'b1);
      @(negedge clock);
      checkVal("vec_busy", 32'(busy), 32'(vecs[i].exp_busy));
      checkVal("vec_m_valid", 32'(m_valid), 32'(vecs[i].exp_mv));
      checkVal("vec_m_data", 32'(m_data), 32'(vecs[i].exp_md));
      checkVal("vec_s_ready", 32'(s_ready), 32'(vecs[i].exp_ready));
      checkVal("vec_grant_id", 32'(grant_id), 32'd0);
      checkOutput();
      model_step();
      @(posedge clock);
      #1;
    end

    // fairness: all four always valid, each sends its own index
    do_reset(4'b0000);
    out_log.delete();
    for (int c = 0; c < 22; c++) begin
      applyStimulus(1'b0, 4'b0000, 4'b1111, 32'h03020100, 1'b1);
      cycle();
    end
    checkVal("rr_count", 32'(out_log.size() >= 16), 32'd1);
    for (int k = 0; k < 16; k++)
      if (k < out_log.size()) checkVal("rr_order", 32'(out_log[k]), 32'(k / 4));

    // early release: req2 drops valid after two beats, req3 waits
    do_reset(4'b0000);
    applyStimulus(1'b0, 4'b0000, 4'b1100, 32'h30200000, 1'b1);
    cycle();
    checkVal("er_first_grant", 32'(grant_id), 32'd2);
    cycle();
    cycle();
    applyStimulus(1'b0, 4'b0000, 4'b1000, 32'h30200000, 1'b1);
    cycle();
    checkVal("er_idle_gap", 32'(busy), 32'd0);
    cycle();
    checkVal("er_next_grant", 32'(grant_id), 32'd3);
    checkVal("er_next_busy", 32'(busy), 32'd1);
    for (int c = 0; c < 6; c++) cycle();

    // reset in the middle of a req1 burst
    do_reset(4'b0000);
    applyStimulus(1'b0, 4'b0000, 4'b0010, 32'h00005100, 1'b1);
    cycle();
    checkVal("mr_grant1", 32'(grant_id), 32'd1);
    cycle();
    cycle();
    applyStimulus(1'b1, 4'b0000, 4'b0010, 32'h00005100, 1'b1);
    cycle();
    checkVal("mr_m_valid", 32'(m_valid), 32'd0);
    checkVal("mr_busy", 32'(busy), 32'd0);
    checkVal("mr_grant_id", 32'(grant_id), 32'd0);
    applyStimulus(1'b0, 4'b0000, 4'b0011, 32'h00005150, 1'b1);
    cycle();
    checkVal("mr_regrant", 32'(grant_id), 32'd0);
    checkVal("mr_regrant_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b1);
    cycle();
    cycle();

    // mask drain: req1 disabled, ready even in reset, data never forwarded
    applyStimulus(1'b1, 4'b0010, 4'b0111, 32'h00424140, 1'b1);
    #2;
    checkVal("mask_rst_ready", 32'(s_ready[1]), 32'd1);
    cycle();
    out_log.delete();
    for (int c = 0; c < 15; c++) begin
      applyStimulus(1'b0, 4'b0010, 4'b0111, 32'h00424140, 1'b1);
      #2;
      checkVal("mask_ready", 32'(s_ready[1]), 32'd1);
      cycle();
    end
    cnt41  = 0;
    seen40 = 1'b0;
    seen42 = 1'b0;
    foreach (out_log[k]) begin
      if (out_log[k] == 8'h41) cnt41++;
      if (out_log[k] == 8'h40) seen40 = 1'b1;
      if (out_log[k] == 8'h42) seen42 = 1'b1;
    end
    checkVal("mask_no_req1", 32'(cnt41), 32'd0);
    checkVal("mask_req0_seen", 32'(seen40), 32'd1);
    checkVal("mask_req2_seen", 32'(seen42), 32'd1);

    // backpressure: two requesters, downstream ready toggles every cycle
    do_reset(4'b0000);
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b0, 4'b0000, 4'b0011, {16'h0, 8'(8'h80 + c), 8'(8'h60 + c)}, 1'(c % 2));
      cycle();
    end

    // randomized traffic against the model and scoreboard
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] v;
      for (int i = 0; i < NUM; i++) v[i] = ($urandom_range(0, 9) < 7);
      applyStimulus(1'($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
                    v, 32'($urandom), 1'($urandom_range(0, 2) != 0));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
